// File: rtl/au_pkg.sv
// Shared types and constants for the AU operation sequencer and its instruction buffer.
package au_pkg;

    localparam int DW = 5;

    localparam logic [2:0] OP_CNT  = 3'b000;
    localparam logic [2:0] OP_LDK  = 3'b001;
    localparam logic [2:0] OP_LDD  = 3'b010;
    localparam logic [2:0] OP_HOLD = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_POW  = 3'b111;

    typedef struct packed {
        logic [2:0]    op;
        logic [DW-1:0] data;
        logic [1:0]    k;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } seq_state_t;

endpackage

// File: rtl/au_instr_fifo.sv
// Instruction buffer: DEPTH-entry FIFO with wrap-around pointers and an occupancy count.
module au_instr_fifo
    import au_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = INSTR_W
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             not_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Push and pop together leave occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset and clear both empty the buffer.
    always_ff @(posedge Clock) begin
        if (!Resetn || clear) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata     = mem_q[rd_ptr_q];
    assign ready     = (count_q != CW'(DEPTH));
    assign not_empty = (count_q != '0);

endmodule

// File: rtl/au_op_sequencer.sv
// Drives the combinational AU from registers, one instruction every two cycles,
// and captures its result into the accumulator r0.
module au_op_sequencer
    import au_pkg::*;
#(
    parameter int DW    = au_pkg::DW,
    parameter int DEPTH = 2
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          clear,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [DW-1:0] instr_data,
    input  logic [1:0]    instr_k,
    output logic [2:0]    au_op,
    output logic [DW-1:0] au_data,
    output logic [1:0]    au_k,
    output logic [3:0]    au_counter,
    output logic [DW-1:0] au_r0,
    input  logic [DW-1:0] au_result,
    output logic [DW-1:0] r0,
    output logic          done,
    output logic          busy
);

    seq_state_t    state_q, state_d;
    logic [2:0]    au_op_q, au_op_d;
    logic [DW-1:0] au_data_q, au_data_d;
    logic [1:0]    au_k_q, au_k_d;
    logic [1:0]    step_q, step_d;
    logic [DW-1:0] r0_q, r0_d;
    logic          done_q, done_d;

    instr_t        push_word_s;
    instr_t        head_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          fifo_not_empty_s;

    assign push_word_s = '{op: instr_op, data: instr_data, k: instr_k};
    assign fifo_push_s = instr_valid && instr_ready;

    au_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .clear     (clear),
        .push      (fifo_push_s),
        .pop       (fifo_pop_s),
        .wdata     (push_word_s),
        .rdata     (head_s),
        .ready     (instr_ready),
        .not_empty (fifo_not_empty_s)
    );

    // Sequencer next-state: load from the buffer head in IDLE, capture the AU result in EXEC.
    always_comb begin
        state_d    = state_q;
        au_op_d    = au_op_q;
        au_data_d  = au_data_q;
        au_k_d     = au_k_q;
        step_d     = step_q;
        r0_d       = r0_q;
        done_d     = 1'b0;
        fifo_pop_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_not_empty_s) begin
                    fifo_pop_s = 1'b1;
                    au_op_d    = head_s.op;
                    au_data_d  = head_s.data;
                    au_k_d     = head_s.k;
                    state_d    = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                r0_d    = au_result;
                step_d  = step_q + 2'd1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; clear behaves exactly like reset and drops any in-flight work.
    always_ff @(posedge Clock) begin
        if (!Resetn || clear) begin
            state_q   <= S_IDLE;
            au_op_q   <= 3'b000;
            au_data_q <= '0;
            au_k_q    <= 2'b00;
            step_q    <= 2'b00;
            r0_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            au_op_q   <= au_op_d;
            au_data_q <= au_data_d;
            au_k_q    <= au_k_d;
            step_q    <= step_d;
            r0_q      <= r0_d;
            done_q    <= done_d;
        end
    end

    assign au_op      = au_op_q;
    assign au_data    = au_data_q;
    assign au_k       = au_k_q;
    assign au_counter = {2'b00, step_q};
    assign au_r0      = r0_q;
    assign r0         = r0_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE) || fifo_not_empty_s;

endmodule
